// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and clamp helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_ud.sv
// rtl/bcd_digit_ud.sv - one BCD up/down digit with clear, clamped load and step
module bcd_digit_ud
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       step,
  input  logic       up_dn,
  output bcd_digit_t digit,
  output logic       is_max,
  output logic       is_min
);
  bcd_digit_t digit_q, digit_d;

  assign digit  = digit_q;
  assign is_max = (digit_q == BCD_MAX);
  assign is_min = (digit_q == BCD_MIN);

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = bcd_clamp(load_val);
    end else if (step) begin
      if (up_dn) digit_d = is_max ? BCD_MIN : digit_q + 4'd1;
      else       digit_d = is_min ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end
endmodule

// File: rtl/bcd_counter_nd.sv
// rtl/bcd_counter_nd.sv - N-digit BCD up/down counter with load, clear, wrap/saturate and sticky overflow
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int WRAP       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    ovf
);
  logic [NUM_DIGITS-1:0] is_max, is_min, step;
  logic [NUM_DIGITS:0]   max_pre, min_pre;
  logic                  step_ok;
  logic                  ovf_q, ovf_d;

  // max_pre[i]/min_pre[i]: every digit below i is 9 / 0
  always_comb begin
    max_pre    = '0;
    min_pre    = '0;
    max_pre[0] = 1'b1;
    min_pre[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      max_pre[i+1] = max_pre[i] & is_max[i];
      min_pre[i+1] = min_pre[i] & is_min[i];
    end
  end

  assign tc      = up_dn ? max_pre[NUM_DIGITS] : min_pre[NUM_DIGITS];
  assign step_ok = enable & ~(tc & (WRAP == 0));

  always_comb begin
    step = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step[i] = step_ok & (up_dn ? max_pre[i] : min_pre[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_ud u_digit (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[4*g +: 4]),
      .step     (step[g]),
      .up_dn    (up_dn),
      .digit    (count[4*g +: 4]),
      .is_max   (is_max[g]),
      .is_min   (is_min[g])
    );
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear)            ovf_d = 1'b0;
    else if (load)        ovf_d = ovf_q;
    else if (enable & tc) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_bcd_counter_nd.sv
// tb/tb_bcd_counter_nd.sv - directed vector bench for bcd_counter_nd across digit counts and wrap modes
module tb_bcd_counter_nd;
  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0, enable = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [23:0] lv = '0;

  logic [11:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic [23:0] cnt_d;
  logic        tc_a, tc_b, tc_c, tc_d, ovf_a, ovf_b, ovf_c, ovf_d;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bcd_counter_nd #(.NUM_DIGITS(3), .WRAP(0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(lv[11:0]), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
  bcd_counter_nd #(.NUM_DIGITS(3), .WRAP(1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(lv[11:0]), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
  bcd_counter_nd #(.NUM_DIGITS(1), .WRAP(0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(lv[3:0]), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));
  bcd_counter_nd #(.NUM_DIGITS(6), .WRAP(0)) u_d (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(lv), .count(cnt_d), .tc(tc_d), .ovf(ovf_d));

  typedef struct {
    string       name;
    logic        rst, clr, en, up, ld;
    logic [11:0] lval;
    logic [11:0] cnt;
    logic        tc, ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, c, e, u, l, input logic [23:0] v);
    @(negedge clk);
    reset = r; clear = c; enable = e; up_dn = u; load = l; lv = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          name        rst clr en up ld  lval    cnt     tc ovf
    vecs.push_back('{"rst1",     1, 0, 1, 1, 0, 12'h000, 12'h000, 0, 0});
    vecs.push_back('{"rst2",     1, 0, 1, 1, 0, 12'h000, 12'h000, 0, 0});
    vecs.push_back('{"ld099",    0, 0, 0, 1, 1, 12'h099, 12'h099, 0, 0});
    vecs.push_back('{"carry",    0, 0, 1, 1, 0, 12'h000, 12'h100, 0, 0});
    vecs.push_back('{"ld998",    0, 0, 0, 1, 1, 12'h998, 12'h998, 0, 0});
    vecs.push_back('{"to999",    0, 0, 1, 1, 0, 12'h000, 12'h999, 1, 0});
    vecs.push_back('{"sat1",     0, 0, 1, 1, 0, 12'h000, 12'h999, 1, 1});
    vecs.push_back('{"sat2",     0, 0, 1, 1, 0, 12'h000, 12'h999, 1, 1});
    vecs.push_back('{"sat3",     0, 0, 1, 1, 0, 12'h000, 12'h999, 1, 1});
    vecs.push_back('{"dirchg",   0, 0, 1, 0, 0, 12'h000, 12'h998, 0, 1});
    vecs.push_back('{"clear",    0, 1, 1, 1, 0, 12'h000, 12'h000, 0, 0});
    vecs.push_back('{"ldF05",    0, 0, 0, 0, 1, 12'hF05, 12'h905, 0, 0});
    vecs.push_back('{"dn1",      0, 0, 1, 0, 0, 12'h000, 12'h904, 0, 0});
    vecs.push_back('{"dn2",      0, 0, 1, 0, 0, 12'h000, 12'h903, 0, 0});
    vecs.push_back('{"dn3",      0, 0, 1, 0, 0, 12'h000, 12'h902, 0, 0});
    vecs.push_back('{"dn4",      0, 0, 1, 0, 0, 12'h000, 12'h901, 0, 0});
    vecs.push_back('{"dn5",      0, 0, 1, 0, 0, 12'h000, 12'h900, 0, 0});
    vecs.push_back('{"borrow",   0, 0, 1, 0, 0, 12'h000, 12'h899, 0, 0});
    vecs.push_back('{"ld_en",    0, 0, 1, 1, 1, 12'h123, 12'h123, 0, 0});
    vecs.push_back('{"clr_ld",   0, 1, 0, 1, 1, 12'h456, 12'h000, 0, 0});
    vecs.push_back('{"up1",      0, 0, 1, 1, 0, 12'h000, 12'h001, 0, 0});
    vecs.push_back('{"up2",      0, 0, 1, 1, 0, 12'h000, 12'h002, 0, 0});
    vecs.push_back('{"rst_mid",  1, 0, 1, 1, 1, 12'h777, 12'h000, 0, 0});
    vecs.push_back('{"dn_sat",   0, 0, 1, 0, 0, 12'h000, 12'h000, 1, 1});
    vecs.push_back('{"ld_ovf",   0, 0, 0, 0, 1, 12'h500, 12'h500, 0, 1});
    vecs.push_back('{"clamp",    0, 0, 0, 1, 1, 12'h9AF, 12'h999, 1, 1});
    vecs.push_back('{"rst_end",  1, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].up, vecs[i].ld, {12'h000, vecs[i].lval});
      chk({vecs[i].name, ".count"}, 32'(cnt_a), 32'(vecs[i].cnt));
      chk({vecs[i].name, ".tc"},    32'(tc_a),  32'(vecs[i].tc));
      chk({vecs[i].name, ".ovf"},   32'(ovf_a), 32'(vecs[i].ovf));
    end

    // wrap mode, three digits
    drive(0, 0, 0, 1, 1, 24'h000999);
    chk("wrap.ld999.tc", 32'(tc_b), 32'd1);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("wrap.up.count", 32'(cnt_b), 32'h000);
    chk("wrap.up.ovf",   32'(ovf_b), 32'd1);
    drive(0, 0, 1, 0, 0, 24'h0);
    chk("wrap.dn.count", 32'(cnt_b), 32'h999);
    chk("wrap.dn.tc",    32'(tc_b),  32'd0);
    drive(0, 0, 1, 0, 0, 24'h0);
    chk("wrap.dn2.count", 32'(cnt_b), 32'h998);

    // single digit
    drive(1, 0, 0, 1, 0, 24'h0);
    drive(0, 0, 0, 1, 1, 24'h000008);
    chk("n1.ld8", 32'(cnt_c), 32'h8);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("n1.up.count", 32'(cnt_c), 32'h9);
    chk("n1.up.tc",    32'(tc_c),  32'd1);
    chk("n1.up.ovf",   32'(ovf_c), 32'd0);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("n1.sat.count", 32'(cnt_c), 32'h9);
    chk("n1.sat.ovf",   32'(ovf_c), 32'd1);
    drive(0, 0, 0, 1, 1, 24'h00000C);
    chk("n1.clamp", 32'(cnt_c), 32'h9);

    // six digits
    drive(1, 0, 0, 1, 0, 24'h0);
    drive(0, 0, 0, 1, 1, 24'h099999);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("n6.carry.count", 32'(cnt_d), 32'h100000);
    chk("n6.carry.tc",    32'(tc_d),  32'd0);
    chk("n6.carry.ovf",   32'(ovf_d), 32'd0);
    drive(0, 0, 0, 1, 1, 24'h999998);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("n6.to_max.count", 32'(cnt_d), 32'h999999);
    chk("n6.to_max.tc",    32'(tc_d),  32'd1);
    drive(0, 0, 1, 1, 0, 24'h0);
    chk("n6.sat.count", 32'(cnt_d), 32'h999999);
    chk("n6.sat.ovf",   32'(ovf_d), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
